// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational palette ROM among NUM_REQ
// pixel pipelines. One lookup is granted per cycle. The colour comes back
// through a single registered response stage, tagged with the requester ID.
module palette_lookup_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             rom_addr,
  input  logic [23:0]            rom_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [23:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] nxt_ptr;
  logic [PTR_W:0]   scan;
  logic             found;
  logic             accept_en;
  logic             accept;

  assign accept_en = !Reset && (!rsp_valid || rsp_ready);
  assign accept    = found && accept_en;
  assign nxt_ptr   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);

  // Scan from rr_ptr upward, wrapping at NUM_REQ. The first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(NUM_REQ)) begin
        scan = scan - (PTR_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[scan[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = scan[PTR_W-1:0];
      end
    end
  end

  // Drive the winner's index to the ROM, even while stalled, because the ROM
  // is read-only. Raise its ready only when the response stage can accept it.
  always_comb begin
    req_ready = '0;
    rom_addr  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (found && !Reset && win == PTR_W'(i)) begin
        rom_addr     = req_addr[8*i +: 8];
        req_ready[i] = accept_en;
      end
    end
  end

  // Response register and rotation pointer. A new accept takes priority over
  // a drain, so back-to-back lookups leave no bubble.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= rom_data;
      rsp_id    <= ID_W'(win);
      rr_ptr    <= nxt_ptr;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
